// File: rtl/riscv_pkg.sv
// Shared types and sizes for the integer register file.
package riscv_pkg;

    localparam int REGFILE_SIZE = 32;

    typedef logic bool;
    localparam bool TRUE  = 1'b1;
    localparam bool FALSE = 1'b0;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_init_state_t;

endpackage

// File: rtl/BRAM_SDP.sv
// Simple dual-port RAM: port A writes, port B reads with one registered cycle (read-first).
module BRAM_SDP
    import riscv_pkg::*;
#(
    parameter int  DWIDTH   = 32,
    parameter int  AWIDTH   = 7,
    parameter bool USE_BRAM = TRUE
) (
    input  logic              clk,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_data,
    input  logic [AWIDTH-1:0] b_addr,
    output logic [DWIDTH-1:0] b_data
);

    generate
        if (USE_BRAM) begin : g_bram
            (* ram_style = "block" *) logic [DWIDTH-1:0] mem [2**AWIDTH];

            // NOTE: the array has no reset branch on purpose; RAM primitives cannot be
            // cleared by reset, so the owner clears them with a write sweep instead.
            always_ff @(posedge clk) begin
                if (a_we) mem[a_addr] <= a_data;
                b_data <= mem[b_addr];
            end
        end else begin : g_lutram
            (* ram_style = "distributed" *) logic [DWIDTH-1:0] mem [2**AWIDTH];

            always_ff @(posedge clk) begin
                if (a_we) mem[a_addr] <= a_data;
                b_data <= mem[b_addr];
            end
        end
    endgenerate

endmodule

// File: rtl/regfile_mt_init.sv
// Multi-thread, multi-read-port register file with post-reset clearing sweep and hard-wired x0.
// Optional same-cycle write-to-read bypass: define REGFILE_WR_BYPASS_EN.
module regfile_mt_init
    import riscv_pkg::*;
#(
    parameter int  DWIDTH              = 32,
    parameter int  NUM_THREADS         = 4,
    parameter int  NUM_READ_PORTS      = 2,
    parameter bool ENABLE_BRAM_REGFILE = TRUE
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [$clog2(NUM_THREADS)-1:0]   i_thread_index_writeback,
    input  logic [$clog2(NUM_THREADS)-1:0]   i_thread_index_decode,
    input  logic [NUM_READ_PORTS*5-1:0]      i_read_addr,
    input  logic [4:0]                       i_write_addr,
    input  logic [DWIDTH-1:0]                i_write_data,
    input  logic                             i_wr_en,
    output logic [NUM_READ_PORTS*DWIDTH-1:0] o_read_data,
    output logic                             o_init_busy
);

    localparam int RF_SIZE = REGFILE_SIZE * NUM_THREADS;
    localparam int AW      = $clog2(RF_SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(RF_SIZE - 1);

    rf_init_state_t  state;
    logic [AW-1:0]   clear_cnt;
    logic            wr_legal;
    logic [AW-1:0]   wr_phys;
    logic            bank_we;
    logic [AW-1:0]   bank_waddr;
    logic [DWIDTH-1:0] bank_wdata;
    logic            rd_init_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= INIT;
            clear_cnt <= '0;
        end else if (state == INIT) begin
            clear_cnt <= clear_cnt + AW'(1);
            if (clear_cnt == LAST_ADDR) state <= READY;
        end
    end

    assign o_init_busy = (state == INIT);
    assign wr_legal    = (state == READY) && i_wr_en && (i_write_addr != 5'd0);
    assign wr_phys     = {i_thread_index_writeback, i_write_addr};

    // The sweep owns the write port while INIT; pipeline writes are dropped then.
    always_comb begin
        bank_we    = wr_legal;
        bank_waddr = wr_phys;
        bank_wdata = i_write_data;
        if (state == INIT) begin
            bank_we    = 1'b1;
            bank_waddr = clear_cnt;
            bank_wdata = '0;
        end
    end

    // Masks reads issued during INIT, including the one in flight at the READY transition.
    always_ff @(posedge clk) begin
        if (!reset_n) rd_init_q <= 1'b1;
        else          rd_init_q <= (state == INIT);
    end

`ifdef REGFILE_WR_BYPASS_EN
    logic [DWIDTH-1:0] wr_data_q;

    always_ff @(posedge clk) begin
        wr_data_q <= i_write_data;
    end
`endif

    generate
        for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
            logic [4:0]        raddr;
            logic [AW-1:0]     rd_phys;
            logic [DWIDTH-1:0] bank_q;
            logic              rd_zero_q;

            assign raddr   = i_read_addr[p*5 +: 5];
            assign rd_phys = {i_thread_index_decode, raddr};

            BRAM_SDP #(
                .DWIDTH   (DWIDTH),
                .AWIDTH   (AW),
                .USE_BRAM (ENABLE_BRAM_REGFILE)
            ) u_bank (
                .clk    (clk),
                .a_we   (bank_we),
                .a_addr (bank_waddr),
                .a_data (bank_wdata),
                .b_addr (rd_phys),
                .b_data (bank_q)
            );

            always_ff @(posedge clk) begin
                rd_zero_q <= (raddr == 5'd0);
            end

`ifdef REGFILE_WR_BYPASS_EN
            logic bp_hit_q;

            always_ff @(posedge clk) begin
                bp_hit_q <= wr_legal && (wr_phys == rd_phys);
            end

            assign o_read_data[p*DWIDTH +: DWIDTH] =
                (rd_init_q || rd_zero_q) ? '0 : (bp_hit_q ? wr_data_q : bank_q);
`else
            assign o_read_data[p*DWIDTH +: DWIDTH] =
                (rd_init_q || rd_zero_q) ? '0 : bank_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mt_init.sv
// Directed self-checking bench for regfile_mt_init (4 threads, 2 read ports).
module tb_regfile_mt_init;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    thread_wb = '0;
    logic [1:0]    thread_dec = '0;
    logic [9:0]    read_addr = '0;
    logic [4:0]    write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic          wr_en = 1'b0;
    logic [2*DW-1:0] read_data;
    logic          init_busy;

    int checks = 0;
    int errors = 0;

    regfile_mt_init dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .i_thread_index_writeback (thread_wb),
        .i_thread_index_decode    (thread_dec),
        .i_read_addr              (read_addr),
        .i_write_addr             (write_addr),
        .i_write_data             (write_data),
        .i_wr_en                  (wr_en),
        .o_read_data              (read_data),
        .o_init_busy              (init_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic do_write(input logic [1:0] t, input logic [4:0] a, input logic [DW-1:0] d);
        thread_wb  = t;
        write_addr = a;
        write_data = d;
        wr_en      = 1'b1;
        tick();
        wr_en      = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] t, input logic [4:0] r0, input logic [4:0] r1);
        thread_dec = t;
        read_addr  = {r1, r0};
        tick();
    endtask

    initial begin
        int n;

        // First reset: busy and output masking, then sweep length.
        do_reset();
        check("busy_after_reset", 32'(init_busy), 32'd1);
        check("rd0_after_reset", read_data[31:0], 32'h0);
        check("rd1_after_reset", read_data[63:32], 32'h0);
        wait_ready(n);
        check("sweep_len_first", 32'(n), 32'd128);

        // Garbage before a second reset must be cleared by its sweep.
        do_write(2'd0, 5'd1, 32'hBAD0_0001);
        do_write(2'd0, 5'd31, 32'hBAD0_001F);
        do_write(2'd1, 5'd10, 32'hBAD1_000A);
        do_write(2'd3, 5'd31, 32'hBAD3_001F);
        do_read(2'd3, 5'd31, 5'd31);
        check("garbage_written", read_data[31:0], 32'hBAD3_001F);
        do_reset();
        wait_ready(n);
        check("sweep_len_second", 32'(n), 32'd128);
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 32; r += 2) begin
                do_read(2'(t), 5'(r), 5'(r + 1));
                check($sformatf("zero_t%0d_x%0d", t, r), read_data[31:0], 32'h0);
                check($sformatf("zero_t%0d_x%0d", t, r + 1), read_data[63:32], 32'h0);
            end
        end

        // Thread isolation.
        do_write(2'd2, 5'd5, 32'hDEADBEEF);
        do_write(2'd1, 5'd5, 32'h12345678);
        do_read(2'd2, 5'd5, 5'd5);
        check("t2x5_p0", read_data[31:0], 32'hDEADBEEF);
        check("t2x5_p1", read_data[63:32], 32'hDEADBEEF);
        do_read(2'd1, 5'd5, 5'd5);
        check("t1x5_p0", read_data[31:0], 32'h12345678);
        check("t1x5_p1", read_data[63:32], 32'h12345678);

        // x0 is hard-wired.
        do_write(2'd0, 5'd0, 32'hFFFFFFFF);
        do_read(2'd0, 5'd0, 5'd0);
        check("x0_p0", read_data[31:0], 32'h0);
        check("x0_p1", read_data[63:32], 32'h0);

        // Read-during-write to the same physical address.
        do_write(2'd3, 5'd7, 32'hA);
        thread_dec = 2'd3;
        read_addr  = {5'd7, 5'd7};
        do_write(2'd3, 5'd7, 32'hB);
`ifdef REGFILE_WR_BYPASS_EN
        check("rdw_same_p0", read_data[31:0], 32'hB);
        check("rdw_same_p1", read_data[63:32], 32'hB);
`else
        check("rdw_same_p0", read_data[31:0], 32'hA);
        check("rdw_same_p1", read_data[63:32], 32'hA);
`endif
        do_read(2'd3, 5'd7, 5'd7);
        check("rdw_next_p0", read_data[31:0], 32'hB);
        check("rdw_next_p1", read_data[63:32], 32'hB);
        // Write to another thread's x7 must not bypass into t3/x7.
        thread_dec = 2'd3;
        read_addr  = {5'd7, 5'd7};
        do_write(2'd2, 5'd7, 32'hC);
        check("rdw_other_thread", read_data[31:0], 32'hB);

        // Writes during INIT are dropped.
        do_reset();
        repeat (3) tick();
        do_write(2'd0, 5'd1, 32'h55);
        wait_ready(n);
        check("sweep_len_after_init_wr", 32'(n), 32'd124);
        do_read(2'd0, 5'd1, 5'd1);
        check("init_wr_dropped", read_data[31:0], 32'h0);

        // Reset mid-sweep restarts the full sweep.
        do_reset();
        repeat (60) tick();
        check("busy_mid_sweep", 32'(init_busy), 32'd1);
        do_reset();
        wait_ready(n);
        check("sweep_len_mid_sweep", 32'(n), 32'd128);

        // Reset mid-operation clears live contents.
        do_write(2'd1, 5'd2, 32'h77);
        do_read(2'd1, 5'd2, 5'd2);
        check("t1x2_before_reset", read_data[63:32], 32'h77);
        do_reset();
        wait_ready(n);
        check("sweep_len_mid_op", 32'(n), 32'd128);
        do_read(2'd1, 5'd2, 5'd2);
        check("t1x2_after_reset_p0", read_data[31:0], 32'h0);
        check("t1x2_after_reset_p1", read_data[63:32], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
